issue_ctrl: RTL and testbench
=============================

ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 Parameter ROB_WIDTH, default 4, ROB tag width; ROB holds 2^ROB_WIDTH entries.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 rdy  input  1  global ready; low freezes the block.
REQ-005 flush  input  1  mispredict clear from ROB, single-cycle pulse.
REQ-006 iq_valid  input  1  instruction queue head is valid.
REQ-007 iq_inst / iq_pc  input  32 / 32  head instruction word and its PC.
REQ-008 iq_pred_jump  input  1  predictor decision for the head instruction.
REQ-009 iq_pop  output  1  combinational; head consumed this cycle.
REQ-010 dec_inst  output  32  combinational copy of iq_inst, drives the decoder.
REQ-011 dec_op, dec_rd, dec_rs1, dec_rs2, dec_imm, dec_is_load_store, dec_is_j_type  input  7,5,5,5,32,1,1  decoder results for dec_inst.
REQ-012 rob_full, rs_full, lsb_full  input  1 each  target cannot accept an entry on the next edge.
REQ-013 rob_issue, rs_issue, lsb_issue  output  1 each  registered one-cycle issue strobes.
REQ-014 is_op, is_rd, is_rs1, is_rs2, is_imm, is_pc, is_pred_jump  output  7,5,5,5,32,32,1  registered issued-instruction payload.
REQ-015 is_tag  output  ROB_WIDTH  registered ROB tag of the issued instruction.
REQ-016 rename_en  output  1  registered; register file marks is_rd busy with is_tag.
REQ-017 stall_cnt  output  32  registered count of stall cycles.

Function
REQ-018 FSM states RUN and RECOVER; reset state RUN.
REQ-019 In RUN, stall = rob_full | (dec_is_load_store ? lsb_full : rs_full).
REQ-020 In RUN with rdy=1, flush=0, iq_valid=1, dec_op!=NULL and stall=0: iq_pop=1 and the instruction issues.
REQ-021 Issue latency: strobes and payload valid exactly one cycle after iq_pop.
REQ-022 Issue: rob_issue=1 always; lsb_issue=1 for loads/stores, else rs_issue=1; never both rs_issue and lsb_issue.
REQ-023 LUI, AUIPC, JAL, JALR, branches and ALU ops route to RS.
REQ-024 rename_en=1 only when is_rd!=0 and op is not a store or branch.
REQ-025 is_tag = tail counter value at issue; tail increments by 1 per issue, wrapping 2^ROB_WIDTH-1 -> 0.
REQ-026 In any cycle without an issue, all three strobes and rename_en are 0 on the next edge; payload holds.
REQ-027 dec_op==NULL with iq_valid=1 and stall=0: iq_pop=1, no strobe, tail unchanged (illegal word dropped).
REQ-028 stall_cnt increments by 1 each RUN cycle with rdy=1, iq_valid=1 and stall=1; saturates at 32'hFFFFFFFF.
REQ-029 flush=1 (with rdy=1) has priority: iq_pop=0, next-edge strobes=0, tail -> 0, state -> RECOVER.
REQ-030 RECOVER lasts exactly one cycle: iq_pop=0, strobes=0, then RUN; a flush in RECOVER restarts the one-cycle RECOVER.
REQ-031 rdy=0: iq_pop=0; every register, including strobes and stall_cnt, holds (downstream units are frozen too).
REQ-032 At most one issue per cycle; no issue while iq_valid=0.

Reset
REQ-033 On rst=1 at a rising edge: state RUN, tail 0, all strobes 0, rename_en 0, stall_cnt 0, payload 0; rst overrides rdy and flush.
REQ-034 While rst=1, iq_pop=0.
REQ-035 Reset asserted mid-stall or in RECOVER discards the pending instruction state; the IQ head is not popped.

Verification
REQ-036 After reset, iq_inst=0x00500093 (addi x1,x0,5), all fulls 0 -> pop in cycle 0; cycle 1: rs_issue=1, rob_issue=1, is_rd=1, is_imm=5, is_tag=0, rename_en=1.
REQ-037 iq_inst=0x00112023 (sw x1,0(x2)), lsb_full=1 for 3 cycles -> no pop for 3 cycles, stall_cnt=3, then lsb_issue=1, rename_en=0.
REQ-038 Issue 17 back-to-back ALU ops with ROB_WIDTH=4 -> is_tag sequence 0..15, then 0.
REQ-039 flush coincident with valid beq 0x00208463 -> iq_pop=0, no strobes next two cycles, next issued is_tag=0.
REQ-040 rdy low for 2 cycles while rob_issue=1 -> outputs frozen at same values, iq_pop=0; resume on rdy high with no second issue.

Source files
------------

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - in-order issue stage: pops the IQ head and dispatches to ROB and RS or LSB
//
// dec_op carries the RISC-V major opcode (inst[6:0]) as reported by the decoder.
// 7'b0000000 is the decoder's NULL marker for an illegal or unrecognised word.
module issue_ctrl #(
  parameter int ROB_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 flush,
  input  logic                 iq_valid,
  input  logic [31:0]          iq_inst,
  input  logic [31:0]          iq_pc,
  input  logic                 iq_pred_jump,
  output logic                 iq_pop,
  output logic [31:0]          dec_inst,
  input  logic [6:0]           dec_op,
  input  logic [4:0]           dec_rd,
  input  logic [4:0]           dec_rs1,
  input  logic [4:0]           dec_rs2,
  input  logic [31:0]          dec_imm,
  input  logic                 dec_is_load_store,
  input  logic                 dec_is_j_type,
  input  logic                 rob_full,
  input  logic                 rs_full,
  input  logic                 lsb_full,
  output logic                 rob_issue,
  output logic                 rs_issue,
  output logic                 lsb_issue,
  output logic [6:0]           is_op,
  output logic [4:0]           is_rd,
  output logic [4:0]           is_rs1,
  output logic [4:0]           is_rs2,
  output logic [31:0]          is_imm,
  output logic [31:0]          is_pc,
  output logic                 is_pred_jump,
  output logic [ROB_WIDTH-1:0] is_tag,
  output logic                 rename_en,
  output logic [31:0]          stall_cnt
);

  localparam logic [6:0] OP_NULL   = 7'b0000000;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_RECOVER = 1'b1;

  logic [0:0]           state;
  logic [ROB_WIDTH-1:0] tail;
  logic                 stall;
  logic                 take;
  logic                 issue;
  logic                 writes_rd;

  // The decoder is purely combinational on the IQ head word.
  assign dec_inst = iq_inst;

  // Target-availability and pop/issue decision for the current head.
  always_comb begin
    stall     = rob_full | (dec_is_load_store ? lsb_full : rs_full);
    take      = !rst && rdy && !flush && (state == ST_RUN) && iq_valid && !stall;
    issue     = take && (dec_op != OP_NULL);
    writes_rd = (dec_rd != 5'd0) && (dec_op != OP_STORE) && (dec_op != OP_BRANCH);
  end

  assign iq_pop = take;

  // State, tail, strobes, payload and stall counter; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_RUN;
      tail         <= '0;
      rob_issue    <= 1'b0;
      rs_issue     <= 1'b0;
      lsb_issue    <= 1'b0;
      rename_en    <= 1'b0;
      stall_cnt    <= '0;
      is_op        <= '0;
      is_rd        <= '0;
      is_rs1       <= '0;
      is_rs2       <= '0;
      is_imm       <= '0;
      is_pc        <= '0;
      is_pred_jump <= 1'b0;
      is_tag       <= '0;
    end else if (rdy) begin
      rob_issue <= issue;
      rs_issue  <= issue && !dec_is_load_store;
      lsb_issue <= issue && dec_is_load_store;
      rename_en <= issue && writes_rd;
      if (flush) begin
        state <= ST_RECOVER;
        tail  <= '0;
      end else if (state == ST_RECOVER) begin
        state <= ST_RUN;
      end else begin
        if (iq_valid && stall && (stall_cnt != 32'hFFFF_FFFF))
          stall_cnt <= stall_cnt + 32'd1;
        if (issue) begin
          is_op        <= dec_op;
          is_rd        <= dec_rd;
          is_rs1       <= dec_rs1;
          is_rs2       <= dec_rs2;
          is_imm       <= dec_imm;
          is_pc        <= iq_pc;
          is_pred_jump <= iq_pred_jump;
          is_tag       <= tail;
          tail         <= tail + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// tb/tb_issue_ctrl.sv - directed plus randomized check of issue_ctrl against a reference model
module tb_issue_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy, flush, iq_valid, iq_pred_jump;
  logic [31:0] iq_inst, iq_pc;
  logic        iq_pop;
  logic [31:0] dec_inst;
  logic [6:0]  dec_op;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [31:0] dec_imm;
  logic        dec_is_load_store, dec_is_j_type;
  logic        rob_full, rs_full, lsb_full;
  logic        rob_issue, rs_issue, lsb_issue;
  logic [6:0]  is_op;
  logic [4:0]  is_rd, is_rs1, is_rs2;
  logic [31:0] is_imm, is_pc;
  logic        is_pred_jump;
  logic [3:0]  is_tag;
  logic        rename_en;
  logic [31:0] stall_cnt;

  issue_ctrl #(.ROB_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .iq_valid(iq_valid), .iq_inst(iq_inst), .iq_pc(iq_pc), .iq_pred_jump(iq_pred_jump),
    .iq_pop(iq_pop), .dec_inst(dec_inst),
    .dec_op(dec_op), .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_imm(dec_imm), .dec_is_load_store(dec_is_load_store), .dec_is_j_type(dec_is_j_type),
    .rob_full(rob_full), .rs_full(rs_full), .lsb_full(lsb_full),
    .rob_issue(rob_issue), .rs_issue(rs_issue), .lsb_issue(lsb_issue),
    .is_op(is_op), .is_rd(is_rd), .is_rs1(is_rs1), .is_rs2(is_rs2),
    .is_imm(is_imm), .is_pc(is_pc), .is_pred_jump(is_pred_jump),
    .is_tag(is_tag), .rename_en(rename_en), .stall_cnt(stall_cnt)
  );

  localparam logic [6:0] OP_NULL   = 7'b0000000;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural view of what the issue stage should show.
  bit          m_recover;
  int          m_tail;
  longint      m_stalls;
  logic        m_rob, m_rs, m_lsb, m_ren;
  logic [6:0]  m_op;
  logic [4:0]  m_rd, m_rs1, m_rs2;
  logic [31:0] m_imm, m_pc;
  logic        m_pj;
  int          m_tag;
  logic        m_pop;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_regs();
    check("rob_issue", rob_issue, m_rob);
    check("rs_issue", rs_issue, m_rs);
    check("lsb_issue", lsb_issue, m_lsb);
    check("rename_en", rename_en, m_ren);
    check("stall_cnt", stall_cnt, m_stalls);
    check("is_tag", is_tag, m_tag);
    check("payload", {is_op, is_rd, is_rs1, is_rs2, is_pred_jump, is_imm}, {m_op, m_rd, m_rs1, m_rs2, m_pj, m_imm});
    check("is_pc", is_pc, m_pc);
  endtask

  task automatic model_step();
    bit blocked;
    bit writes;
    m_pop = 1'b0;
    if (rst) begin
      m_recover = 0; m_tail = 0; m_stalls = 0;
      m_rob = 0; m_rs = 0; m_lsb = 0; m_ren = 0;
      m_op = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_pc = 0; m_pj = 0; m_tag = 0;
    end else if (rdy) begin
      m_rob = 0; m_rs = 0; m_lsb = 0; m_ren = 0;
      if (flush) begin
        m_recover = 1; m_tail = 0;
      end else if (m_recover) begin
        m_recover = 0;
      end else begin
        blocked = rob_full || (dec_is_load_store ? lsb_full : rs_full);
        if (iq_valid && blocked && m_stalls < 64'hFFFF_FFFF) m_stalls++;
        m_pop = iq_valid && !blocked;
        if (m_pop && dec_op != OP_NULL) begin
          writes = (dec_rd != 0) && !(dec_op inside {OP_STORE, OP_BRANCH});
          m_rob = 1; m_lsb = dec_is_load_store; m_rs = !dec_is_load_store; m_ren = writes;
          m_op = dec_op; m_rd = dec_rd; m_rs1 = dec_rs1; m_rs2 = dec_rs2;
          m_imm = dec_imm; m_pc = iq_pc; m_pj = iq_pred_jump;
          m_tag = m_tail;
          m_tail = (m_tail + 1) % 16;
        end
      end
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    #1;
    model_step();
    check("iq_pop", iq_pop, m_pop);
    check("dec_inst", dec_inst, iq_inst);
    @(posedge clk);
    @(negedge clk);
    check_regs();
  endtask

  task automatic set_inst(input logic [31:0] inst, input logic [6:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
    iq_inst = inst; dec_op = op; dec_rd = rd; dec_rs1 = rs1; dec_rs2 = rs2; dec_imm = imm;
    dec_is_load_store = (op == OP_LOAD) || (op == OP_STORE);
    dec_is_j_type = (op == OP_JAL);
  endtask

  task automatic do_reset();
    rst = 1; cycle(); rst = 0;
  endtask

  initial begin
    logic [6:0] ops [10];
    ops = '{OP_NULL, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_ALU};
    rst = 1; rdy = 1; flush = 0; iq_valid = 0; iq_pred_jump = 0; iq_pc = 32'h100;
    rob_full = 0; rs_full = 0; lsb_full = 0;
    set_inst(32'h0, OP_NULL, 0, 0, 0, 0);
    @(negedge clk);
    do_reset();

    // addi x1,x0,5 issues right after reset
    iq_valid = 1; set_inst(32'h00500093, OP_IMM, 5'd1, 5'd0, 5'd0, 32'd5);
    cycle();
    check("addi_rs", rs_issue, 1'b1);
    check("addi_rd", is_rd, 5'd1);
    check("addi_imm", is_imm, 32'd5);
    check("addi_tag", is_tag, 4'd0);
    check("addi_ren", rename_en, 1'b1);

    // sw x1,0(x2) held off by a full LSB for three cycles
    do_reset();
    iq_valid = 1; set_inst(32'h00112023, OP_STORE, 5'd0, 5'd2, 5'd1, 32'd0);
    lsb_full = 1;
    repeat (3) cycle();
    check("sw_stalls", stall_cnt, 32'd3);
    lsb_full = 0;
    cycle();
    check("sw_lsb", lsb_issue, 1'b1);
    check("sw_ren", rename_en, 1'b0);

    // 17 back-to-back ALU ops: tag wraps after 15
    do_reset();
    for (int i = 0; i < 17; i++) begin
      iq_pc = 32'h200 + 4 * i;
      set_inst(32'h00208033, OP_ALU, 5'd1 + i[4:0], 5'd1, 5'd2, 32'd0);
      cycle();
      check("wrap_tag", is_tag, i % 16);
    end

    // flush coincident with a valid beq, then recovery
    set_inst(32'h00208463, OP_BRANCH, 5'd8, 5'd1, 5'd2, 32'd8);
    flush = 1; cycle(); flush = 0;
    check("flush_rob", rob_issue, 1'b0);
    set_inst(32'h00500093, OP_IMM, 5'd1, 5'd0, 5'd0, 32'd5);
    cycle();
    check("recover_rob", rob_issue, 1'b0);
    cycle();
    check("post_flush_tag", is_tag, 4'd0);
    check("post_flush_rob", rob_issue, 1'b1);

    // rdy low while a strobe is up: everything freezes
    rdy = 0; repeat (2) cycle();
    check("frozen_rob", rob_issue, 1'b1);
    rdy = 1; iq_valid = 0; cycle();
    check("resume_rob", rob_issue, 1'b0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 99) < 2);
      rdy      = ($urandom_range(0, 99) < 85);
      flush    = ($urandom_range(0, 99) < 5);
      iq_valid = ($urandom_range(0, 99) < 80);
      rob_full = ($urandom_range(0, 99) < 15);
      rs_full  = ($urandom_range(0, 99) < 20);
      lsb_full = ($urandom_range(0, 99) < 25);
      iq_pred_jump = $urandom_range(0, 1);
      iq_pc    = $urandom;
      set_inst($urandom, ops[$urandom_range(0, 9)], ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
               5'($urandom), 5'($urandom), $urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
